// File: rtl/dsp48a1_mac_ctrl.sv
// Streaming multiply-accumulate sequencer for a DSP48A1 slice.
// Operand pairs are passed straight through to the slice's A1/B1 registers.
// A small token pipeline mirrors the slice's M and P stages so that each
// enable and OPMODE lines up with its operands, including across input
// bubbles. One dot product is returned per N_TAPS-pair vector.
module dsp48a1_mac_ctrl #(
   parameter int N_TAPS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [17:0] s_a,
   input  logic [17:0] s_b,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [47:0] m_data,
   output logic [17:0] dsp_a,
   output logic [17:0] dsp_b,
   output logic        dsp_cea,
   output logic        dsp_ceb,
   output logic        dsp_cem,
   output logic        dsp_cep,
   output logic        dsp_ceopmode,
   output logic [7:0]  dsp_opmode,
   output logic        dsp_rst,
   input  logic [47:0] dsp_p
);

   localparam int              CW       = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
   localparam logic [CW-1:0]   LAST_TAP = CW'(N_TAPS - 1);

   // OPMODE values: Z=0/X=M starts a new sum, Z=P/X=M accumulates.
   localparam logic [7:0] OPMODE_LOAD  = 8'h01;
   localparam logic [7:0] OPMODE_ACCUM = 8'h09;

   typedef enum logic [1:0] {
      ST_ACCEPT,
      ST_DRAIN,
      ST_HOLD
   } state_t;

   // Token travelling alongside the operands through the M stage.
   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } tok_m_t;

   // By the P stage only validity and end-of-vector still matter.
   typedef struct packed {
      logic valid;
      logic last;
   } tok_p_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [CW-1:0] r_tap_cnt;
   tok_m_t        r_v1;
   tok_p_t        r_v2;
   logic          r_p_last;
   logic [47:0]   r_m_data;

   logic          w_in_accept;
   logic          w_in_hold;
   logic          w_accept;
   logic          w_capture;
   tok_m_t        w_tok;

   // A pair is taken only while accepting and never during reset.
   assign w_accept = w_in_accept & s_valid & ~rst;

   assign w_tok.valid = w_accept;
   assign w_tok.first = w_accept & (r_tap_cnt == '0);
   assign w_tok.last  = w_accept & (r_tap_cnt == LAST_TAP);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_ACCEPT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state and state-decoded strobes.
   always_comb begin
      w_state_next = r_state;
      w_in_accept  = 1'b0;
      w_in_hold    = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         ST_ACCEPT: begin
            w_in_accept = 1'b1;
            if (s_valid && (r_tap_cnt == LAST_TAP)) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The last product has just landed in P: take it.
            if (r_p_last) begin
               w_capture    = 1'b1;
               w_state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            w_in_hold = 1'b1;
            if (m_ready) begin
               w_state_next = ST_ACCEPT;
            end
         end
         default: begin
            w_state_next = ST_ACCEPT;
         end
      endcase
   end

   // Tap counter: position of the next accepted pair within its vector.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tap_cnt <= '0;
      end else if (w_accept) begin
         r_tap_cnt <= (r_tap_cnt == LAST_TAP) ? '0 : r_tap_cnt + 1'b1;
      end
   end

   // Token pipeline: v1 tracks the M stage, v2 the P stage, then a flag
   // marking the cycle in which P holds the finished sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1     <= '0;
         r_v2     <= '0;
         r_p_last <= 1'b0;
      end else begin
         r_v1       <= w_tok;
         r_v2.valid <= r_v1.valid;
         r_v2.last  <= r_v1.valid & r_v1.last;
         r_p_last   <= r_v2.valid & r_v2.last;
      end
   end

   // Result register, loaded once per vector from the slice P output.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_data <= '0;
      end else if (w_capture) begin
         r_m_data <= dsp_p;
      end
   end

   assign s_ready      = w_in_accept & ~rst;
   assign m_valid      = w_in_hold & ~rst;
   assign m_data       = r_m_data;

   assign dsp_a        = s_a;
   assign dsp_b        = s_b;
   assign dsp_cea      = w_accept;
   assign dsp_ceb      = w_accept;
   assign dsp_cem      = r_v1.valid & ~rst;
   assign dsp_ceopmode = r_v1.valid & ~rst;
   assign dsp_cep      = r_v2.valid & ~rst;
   assign dsp_opmode   = rst ? 8'h00 : (r_v1.first ? OPMODE_LOAD : OPMODE_ACCUM);
   assign dsp_rst      = rst;

endmodule

// File: tb/tb_dsp48a1_mac_ctrl.sv
// Bench for dsp48a1_mac_ctrl: two instances (N_TAPS=4 and N_TAPS=1), each
// driving a small behavioural DSP48A1 model that closes the loop on dsp_p.
module tb_dsp48a1_mac_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // ---------------- N_TAPS = 4 instance ----------------
   logic        s_valid4 = 1'b0, s_ready4, m_valid4, m_ready4 = 1'b1;
   logic [17:0] s_a4 = '0, s_b4 = '0, dsp_a4, dsp_b4;
   logic [47:0] m_data4, dsp_p4;
   logic        cea4, ceb4, cem4, cep4, ceop4, dsp_rst4;
   logic [7:0]  opmode4;

   dsp48a1_mac_ctrl #(.N_TAPS(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .s_valid(s_valid4), .s_ready(s_ready4), .s_a(s_a4), .s_b(s_b4),
      .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4),
      .dsp_a(dsp_a4), .dsp_b(dsp_b4), .dsp_cea(cea4), .dsp_ceb(ceb4),
      .dsp_cem(cem4), .dsp_cep(cep4), .dsp_ceopmode(ceop4),
      .dsp_opmode(opmode4), .dsp_rst(dsp_rst4), .dsp_p(dsp_p4)
   );

   // ---------------- N_TAPS = 1 instance ----------------
   logic        s_valid1 = 1'b0, s_ready1, m_valid1, m_ready1 = 1'b1;
   logic [17:0] s_a1 = '0, s_b1 = '0, dsp_a1, dsp_b1;
   logic [47:0] m_data1, dsp_p1;
   logic        cea1, ceb1, cem1, cep1, ceop1, dsp_rst1;
   logic [7:0]  opmode1;

   dsp48a1_mac_ctrl #(.N_TAPS(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .s_valid(s_valid1), .s_ready(s_ready1), .s_a(s_a1), .s_b(s_b1),
      .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
      .dsp_a(dsp_a1), .dsp_b(dsp_b1), .dsp_cea(cea1), .dsp_ceb(ceb1),
      .dsp_cem(cem1), .dsp_cep(cep1), .dsp_ceopmode(ceop1),
      .dsp_opmode(opmode1), .dsp_rst(dsp_rst1), .dsp_p(dsp_p1)
   );

   // Slice model (A1/B1 -> M -> P, registered OPMODE, sync reset), instance 4.
   logic signed [17:0] sa4, sb4;
   logic signed [35:0] sm4;
   logic [7:0]         sop4;
   logic [47:0]        sp4;
   assign dsp_p4 = sp4;
   always @(posedge clk) begin
      if (dsp_rst4) begin
         sa4 <= '0; sb4 <= '0; sm4 <= '0; sop4 <= '0; sp4 <= '0;
      end else begin
         if (cea4)  sa4  <= dsp_a4;
         if (ceb4)  sb4  <= dsp_b4;
         if (cem4)  sm4  <= sa4 * sb4;
         if (ceop4) sop4 <= opmode4;
         if (cep4)  sp4  <= ((sop4[3:2] == 2'b10) ? sp4 : 48'd0)
                          + ((sop4[1:0] == 2'b01) ? {{12{sm4[35]}}, sm4} : 48'd0);
      end
   end

   // Slice model, instance 1.
   logic signed [17:0] sa1, sb1;
   logic signed [35:0] sm1;
   logic [7:0]         sop1;
   logic [47:0]        sp1;
   assign dsp_p1 = sp1;
   always @(posedge clk) begin
      if (dsp_rst1) begin
         sa1 <= '0; sb1 <= '0; sm1 <= '0; sop1 <= '0; sp1 <= '0;
      end else begin
         if (cea1)  sa1  <= dsp_a1;
         if (ceb1)  sb1  <= dsp_b1;
         if (cem1)  sm1  <= sa1 * sb1;
         if (ceop1) sop1 <= opmode1;
         if (cep1)  sp1  <= ((sop1[3:2] == 2'b10) ? sp1 : 48'd0)
                          + ((sop1[1:0] == 2'b01) ? {{12{sm1[35]}}, sm1} : 48'd0);
      end
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required end of test");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        sv;
      logic [17:0] a;
      logic [17:0] b;
      logic        mr;
      logic        rdy;
      logic        cem;
      logic        cep;
      logic [7:0]  op;
      logic        mv;
      logic [47:0] md;
   } vec_t;

   function automatic vec_t mk(input logic sv, input int a, input int b, input logic mr,
                               input logic rdy, input logic cem, input logic cep,
                               input logic [7:0] op, input logic mv, input int md);
      vec_t v;
      v.sv = sv; v.a = 18'(a); v.b = 18'(b); v.mr = mr;
      v.rdy = rdy; v.cem = cem; v.cep = cep; v.op = op; v.mv = mv; v.md = 48'(md);
      return v;
   endfunction

   // One full vector of four identical pairs on instance 4, result checked.
   task automatic send_vec4(input int a, input int b, input int exp, input string nm);
      int lat;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         s_valid4 = 1'b1; s_a4 = 18'(a); s_b4 = 18'(b); m_ready4 = 1'b1;
         #1;
         chk($sformatf("%s rdy%0d", nm, i), 48'(s_ready4), 48'd1);
      end
      @(posedge clk); #1;
      s_valid4 = 1'b0;
      #1;
      lat = 1;
      while (!m_valid4 && lat < 20) begin
         @(posedge clk); #2;
         lat++;
      end
      chk({nm, " latency"}, 48'(lat), 48'd4);
      chk({nm, " m_data"}, m_data4, 48'(exp));
      $display("vector %s: latency %0d m_data %0d", nm, lat, m_data4);
      @(posedge clk); #2;
      chk({nm, " m_valid drop"}, 48'(m_valid4), 48'd0);
      chk({nm, " s_ready back"}, 48'(s_ready4), 48'd1);
   endtask

   vec_t tbl[22];

   initial begin
      int seen;

      // Back-to-back vector (rows 0-7), then the same pairs with bubbles.
      tbl[0]  = mk(1, 1, 2, 1, 1, 0, 0, 8'h00, 0, 0);
      tbl[1]  = mk(1, 3, 4, 1, 1, 1, 0, 8'h01, 0, 0);
      tbl[2]  = mk(1, 5, 6, 1, 1, 1, 1, 8'h09, 0, 0);
      tbl[3]  = mk(1, 7, 8, 1, 1, 1, 1, 8'h09, 0, 0);
      tbl[4]  = mk(0, 0, 0, 1, 0, 1, 1, 8'h09, 0, 0);
      tbl[5]  = mk(0, 0, 0, 1, 0, 0, 1, 8'h00, 0, 0);
      tbl[6]  = mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0);
      tbl[7]  = mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 1, 100);
      tbl[8]  = mk(1, 1, 2, 1, 1, 0, 0, 8'h00, 0, 100);
      tbl[9]  = mk(0, 0, 0, 1, 1, 1, 0, 8'h01, 0, 100);
      tbl[10] = mk(0, 0, 0, 1, 1, 0, 1, 8'h00, 0, 100);
      tbl[11] = mk(1, 3, 4, 1, 1, 0, 0, 8'h00, 0, 100);
      tbl[12] = mk(0, 0, 0, 1, 1, 1, 0, 8'h09, 0, 100);
      tbl[13] = mk(0, 0, 0, 1, 1, 0, 1, 8'h00, 0, 100);
      tbl[14] = mk(1, 5, 6, 1, 1, 0, 0, 8'h00, 0, 100);
      tbl[15] = mk(0, 0, 0, 1, 1, 1, 0, 8'h09, 0, 100);
      tbl[16] = mk(0, 0, 0, 1, 1, 0, 1, 8'h00, 0, 100);
      tbl[17] = mk(1, 7, 8, 1, 1, 0, 0, 8'h00, 0, 100);
      tbl[18] = mk(0, 0, 0, 1, 0, 1, 0, 8'h09, 0, 100);
      tbl[19] = mk(0, 0, 0, 1, 0, 0, 1, 8'h00, 0, 100);
      tbl[20] = mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 100);
      tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 100);

      // Reset held two cycles with s_valid high.
      s_valid4 = 1'b1; s_valid1 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #2;
      chk("rst s_ready", 48'(s_ready4), 48'd0);
      chk("rst m_valid", 48'(m_valid4), 48'd0);
      chk("rst m_data", m_data4, 48'd0);
      chk("rst ces", 48'({cea4, ceb4, cem4, cep4, ceop4}), 48'd0);
      chk("rst opmode", 48'(opmode4), 48'd0);
      chk("rst dsp_rst", 48'(dsp_rst4), 48'd1);
      chk("rst s_ready n1", 48'(s_ready1), 48'd0);
      s_valid4 = 1'b0; s_valid1 = 1'b0; rst = 1'b0;
      #1;
      chk("release s_ready", 48'(s_ready4), 48'd1);
      chk("release dsp_rst", 48'(dsp_rst4), 48'd0);
      chk("release s_ready n1", 48'(s_ready1), 48'd1);
      $display("reset: s_ready=%0d m_valid=%0d m_data=%0d", s_ready4, m_valid4, m_data4);

      // Table: back-to-back vector then bubbled vector.
      for (int i = 0; i < 22; i++) begin
         @(posedge clk); #1;
         s_valid4 = tbl[i].sv; s_a4 = tbl[i].a; s_b4 = tbl[i].b; m_ready4 = tbl[i].mr;
         #1;
         chk($sformatf("row%0d s_ready", i), 48'(s_ready4), 48'(tbl[i].rdy));
         chk($sformatf("row%0d cea", i), 48'(cea4), 48'(tbl[i].sv & tbl[i].rdy));
         chk($sformatf("row%0d cem", i), 48'(cem4), 48'(tbl[i].cem));
         chk($sformatf("row%0d cep", i), 48'(cep4), 48'(tbl[i].cep));
         if (tbl[i].cem) chk($sformatf("row%0d opmode", i), 48'(opmode4), 48'(tbl[i].op));
         chk($sformatf("row%0d m_valid", i), 48'(m_valid4), 48'(tbl[i].mv));
         chk($sformatf("row%0d m_data", i), m_data4, tbl[i].md);
         $display("row %0d: sv=%0d rdy=%0d cem=%0d cep=%0d op=%02h mv=%0d md=%0d",
                  i, s_valid4, s_ready4, cem4, cep4, opmode4, m_valid4, m_data4);
      end

      // Backpressure: result held, inputs ignored while m_ready stays low.
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         s_valid4 = 1'b1; s_a4 = 18'd7; s_b4 = 18'd7; m_ready4 = 1'b0;
         #1;
         chk($sformatf("bp%0d m_valid", i), 48'(m_valid4), 48'd1);
         chk($sformatf("bp%0d m_data", i), m_data4, 48'd100);
         chk($sformatf("bp%0d s_ready", i), 48'(s_ready4), 48'd0);
         chk($sformatf("bp%0d cea", i), 48'(cea4), 48'd0);
      end
      @(posedge clk); #1;
      s_valid4 = 1'b0; m_ready4 = 1'b1;
      #1;
      chk("bp release m_valid", 48'(m_valid4), 48'd1);
      $display("backpressure: held m_data=%0d", m_data4);
      send_vec4(1, 1, 4, "ones");

      // Reset after two accepts: vector discarded, no residue.
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         s_valid4 = 1'b1; s_a4 = 18'd9; s_b4 = 18'd9;
      end
      @(posedge clk); #1;
      s_valid4 = 1'b0; rst = 1'b1;
      #1;
      chk("midrst cem", 48'(cem4), 48'd0);
      chk("midrst dsp_rst", 48'(dsp_rst4), 48'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midrst m_data", m_data4, 48'd0);
      chk("midrst s_ready", 48'(s_ready4), 48'd1);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #2;
         if (m_valid4) seen++;
      end
      chk("midrst no m_valid", 48'(seen), 48'd0);
      $display("reset mid-vector: m_valid cycles after reset=%0d", seen);
      send_vec4(2, 3, 24, "after-rst");

      // N_TAPS=1: continuous (5,7) stream, 5-cycle vector period.
      for (int cyc = 0; cyc < 11; cyc++) begin
         @(posedge clk); #1;
         s_valid1 = 1'b1; s_a1 = 18'd5; s_b1 = 18'd7; m_ready1 = 1'b1;
         #1;
         chk($sformatf("n1 c%0d s_ready", cyc), 48'(s_ready1), 48'(cyc % 5 == 0));
         chk($sformatf("n1 c%0d cem", cyc), 48'(cem1), 48'(cyc % 5 == 1));
         chk($sformatf("n1 c%0d cep", cyc), 48'(cep1), 48'(cyc % 5 == 2));
         chk($sformatf("n1 c%0d m_valid", cyc), 48'(m_valid1), 48'(cyc % 5 == 4));
         if (cyc % 5 == 1) chk($sformatf("n1 c%0d opmode", cyc), 48'(opmode1), 48'h01);
         if (cyc % 5 == 4) chk($sformatf("n1 c%0d m_data", cyc), m_data1, 48'd35);
         $display("n1 cycle %0d: rdy=%0d cem=%0d cep=%0d op=%02h mv=%0d md=%0d",
                  cyc, s_ready1, cem1, cep1, opmode1, m_valid1, m_data1);
      end
      s_valid1 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
